// File: rtl/aes_round_sequencer.sv
// Sequences round/max_round for external AES Encryption/Decryption cores, captures their
// results and shows one result byte on three 7-segment digits. Optional macro: AES_RESULT_CNT_EN.

module binary_to_bcd (
    input  logic [7:0]  bin_i,
    output logic [11:0] bcd_o
);
    logic [11:0] acc;

    // Double dabble: add 3 to any digit >= 5 before each shift.
    always_comb begin
        acc = '0;
        for (int i = 7; i >= 0; i--) begin
            if (acc[3:0] >= 4'd5) begin
                acc[3:0] = acc[3:0] + 4'd3;
            end
            if (acc[7:4] >= 4'd5) begin
                acc[7:4] = acc[7:4] + 4'd3;
            end
            if (acc[11:8] >= 4'd5) begin
                acc[11:8] = acc[11:8] + 4'd3;
            end
            acc = {acc[10:0], bin_i[i]};
        end
        bcd_o = acc;
    end
endmodule

module seven_seg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    // Active-high segments, bit order gfedcba.
    always_comb begin
        seg_o = 7'h00;
        case (digit_i)
            4'd0: seg_o = 7'h3F;
            4'd1: seg_o = 7'h06;
            4'd2: seg_o = 7'h5B;
            4'd3: seg_o = 7'h4F;
            4'd4: seg_o = 7'h66;
            4'd5: seg_o = 7'h6D;
            4'd6: seg_o = 7'h7D;
            4'd7: seg_o = 7'h07;
            4'd8: seg_o = 7'h7F;
            4'd9: seg_o = 7'h6F;
            default: seg_o = 7'h00;
        endcase
    end
endmodule

module aes_round_sequencer #(
    parameter int CNT_W     = 6,
    parameter int DISP_BYTE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [127:0]     data_in,
    input  logic [255:0]     key_in,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] max_round,
    input  logic [127:0]     enc_state,
    input  logic [127:0]     dec_state,
    output logic [127:0]     ct_out,
    output logic [127:0]     pt_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             match,
    output logic [20:0]      sevseg,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic [1:0]       dbg_state_o
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in HOLD, and HOLD data is frozen until taken.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DEC  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic [CNT_W-1:0] nr_sel;
    logic [CNT_W-1:0] two_nr;
    logic [127:0]     pt_lat_q, pt_lat_d;
    logic [255:0]     key_q, key_d;
    logic [127:0]     ct_q, ct_d;
    logic [127:0]     pt_q, pt_d;
    logic             match_q, match_d;
    logic             ready_q;
    logic             key_unused;
    logic [7:0]       disp_byte;
    logic [11:0]      bcd;

    always_comb begin
        case (sel)
            2'd0:    nr_sel = CNT_W'(10);
            2'd1:    nr_sel = CNT_W'(12);
            default: nr_sel = CNT_W'(14);
        endcase
    end

    assign two_nr = nr_q << 1;

    // The job key is held for the cores' key schedule; nothing in this block consumes it.
    assign key_unused = ^key_q;

    // ENC spans rounds 0..Nr and DEC spans Nr..2Nr (round holds on the hand-over edge),
    // so a job takes 2*Nr+2 cycles from accept to out_valid.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        nr_d     = nr_q;
        pt_lat_d = pt_lat_q;
        key_d    = key_q;
        ct_d     = ct_q;
        pt_d     = pt_q;
        match_d  = match_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && ready_q) begin
                    pt_lat_d = data_in;
                    key_d    = key_in;
                    nr_d     = nr_sel;
                    round_d  = '0;
                    state_d  = S_ENC;
                end
            end
            S_ENC: begin
                if (round_q == nr_q) begin
                    ct_d    = enc_state;
                    state_d = S_DEC;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_DEC: begin
                if (round_q == two_nr) begin
                    pt_d    = dec_state;
                    match_d = (dec_state == pt_lat_q);
                    state_d = S_HOLD;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            nr_q     <= CNT_W'(10);
            pt_lat_q <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            pt_q     <= '0;
            match_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            nr_q     <= nr_d;
            pt_lat_q <= pt_lat_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            pt_q     <= pt_d;
            match_q  <= match_d;
            ready_q  <= (state_d == S_IDLE);
        end
    end

    assign in_ready    = ready_q;
    assign round       = round_q;
    assign max_round   = nr_q;
    assign ct_out      = ct_q;
    assign pt_out      = pt_q;
    assign out_valid   = (state_q == S_HOLD);
    assign busy        = (state_q == S_ENC) || (state_q == S_DEC);
    assign match       = match_q;
    assign dbg_state_o = state_q;

`ifdef AES_RESULT_CNT_EN
    logic       cap_pt;
    logic [7:0] pass_q, fail_q;

    assign cap_pt = (state_q == S_DEC) && (round_q == two_nr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (cap_pt) begin
            if (match_d) begin
                if (pass_q != 8'hFF) begin
                    pass_q <= pass_q + 8'd1;
                end
            end else begin
                if (fail_q != 8'hFF) begin
                    fail_q <= fail_q + 8'd1;
                end
            end
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

    // Ciphertext is shown while decrypting; the decrypted text otherwise.
    assign disp_byte = (state_q == S_DEC) ? ct_q[DISP_BYTE*8 +: 8] : pt_q[DISP_BYTE*8 +: 8];

    binary_to_bcd u_bcd (
        .bin_i (disp_byte),
        .bcd_o (bcd)
    );

    seven_seg u_seg_hund (
        .digit_i (bcd[11:8]),
        .seg_o   (sevseg[20:14])
    );

    seven_seg u_seg_tens (
        .digit_i (bcd[7:4]),
        .seg_o   (sevseg[13:7])
    );

    seven_seg u_seg_unit (
        .digit_i (bcd[3:0]),
        .seg_o   (sevseg[6:0])
    );
endmodule
